// File: rtl/hpdl_pkg.sv
// Shared constants, state encoding and byte helpers
// for the HPDL buffer dump.
package hpdl_pkg;

  localparam logic [7:0] CH_LBRACK = 8'h5B;
  localparam logic [7:0] CH_RBRACK = 8'h5D;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_MIN    = 8'h20;
  localparam logic [7:0] CH_MAX    = 8'h7E;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD_ADDR,
    S_RD_DATA,
    S_CHAR,
    S_TRL,
    S_DONE
  } state_t;

  // Non-printable bytes (incl. anything with bit 7 set) become '.'
  function automatic logic [7:0] sanitize(input logic [7:0] b);
    return (b < CH_MIN || b > CH_MAX) ? CH_DOT : b;
  endfunction

  // Trailer sequence: ']' CR LF
  function automatic logic [7:0] trailer(input logic [1:0] idx);
    logic [7:0] r;
    r = CH_LF;
    unique case (idx)
      2'd0:    r = CH_RBRACK;
      2'd1:    r = CH_CR;
      default: r = CH_LF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 transmit serializer with valid/ready intake.
// Ready also rises in the last stop-bit cycle so bytes chain gap-free.
module uart_tx_serializer #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int PERIOD = CLK_HZ / BAUD;
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] CELL_LAST = CW'(PERIOD - 1);

  logic          busy;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shift;
  logic          cell_end;
  logic          last_bit;
  logic          accept;

  assign cell_end = baud_cnt == CELL_LAST;
  assign last_bit = bit_cnt == 4'd9;
  assign ready    = !busy || (cell_end && last_bit);
  assign accept   = valid && ready;

  // Bit-cell timing and shift-out; start bit goes out the cycle after accept
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '1;
      tx       <= 1'b1;
    end else if (accept) begin
      busy     <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= {1'b1, data};
      tx       <= 1'b0;
    end else if (busy) begin
      if (cell_end) begin
        baud_cnt <= '0;
        if (last_bit) begin
          busy    <= 1'b0;
          bit_cnt <= '0;
          tx      <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          tx      <= shift[0];
          shift   <= {1'b1, shift[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hpdl_buffer_dump.sv
// Dumps the display character memory as one framed,
// sanitised line over an 8N1 UART.
module hpdl_buffer_dump
  import hpdl_pkg::*;
#(
  parameter int CLK_HZ         = 12000000,
  parameter int BAUD           = 115200,
  parameter int DISPLAY_LENGTH = 16
) (
  input  logic       CLK_i,
  input  logic       RST_i,
  input  logic       i_dump_start,
  output logic [3:0] o_rd_address,
  input  logic [7:0] i_rd_data,
  output logic       UART_TX,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [3:0] LAST_ADDR = 4'(DISPLAY_LENGTH - 1);

  state_t     state;
  state_t     nxt;
  logic [3:0] addr;
  logic [7:0] ch;
  logic [1:0] trl_idx;
  logic       valid;
  logic       ready;
  logic [7:0] tx_byte;
  logic       at_last;

  assign at_last      = addr >= LAST_ADDR;
  assign o_rd_address = RST_i ? 4'd0 : addr;
  assign o_busy       = !RST_i && (state != S_IDLE);
  assign o_done       = !RST_i && (state == S_DONE);

  uart_tx_serializer #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_ser (
    .clk  (CLK_i),
    .rst  (RST_i),
    .valid(valid),
    .data (tx_byte),
    .ready(ready),
    .tx   (UART_TX)
  );

  // Next-state and byte offer; the next read runs while the
  // previous byte is still on the wire
  always_comb begin
    nxt     = state;
    valid   = 1'b0;
    tx_byte = CH_LBRACK;
    unique case (state)
      S_IDLE: begin
        if (i_dump_start) nxt = S_HDR;
      end
      S_HDR: begin
        valid = 1'b1;
        if (ready) nxt = S_RD_ADDR;
      end
      S_RD_ADDR: nxt = S_RD_DATA;
      S_RD_DATA: nxt = S_CHAR;
      S_CHAR: begin
        valid   = 1'b1;
        tx_byte = ch;
        if (ready) nxt = at_last ? S_TRL : S_RD_ADDR;
      end
      S_TRL: begin
        if (trl_idx != 2'd3) begin
          valid   = 1'b1;
          tx_byte = trailer(trl_idx);
        end else if (ready) begin
          nxt = S_DONE;
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // State, read address, captured character and trailer index
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state   <= S_IDLE;
      addr    <= '0;
      ch      <= '0;
      trl_idx <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE || state == S_DONE) begin
        addr    <= '0;
        trl_idx <= '0;
      end
      if (state == S_RD_DATA) ch <= sanitize(i_rd_data);
      if (state == S_CHAR && ready && !at_last) addr <= addr + 4'd1;
      if (state == S_TRL && valid && ready) trl_idx <= trl_idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_hpdl_buffer_dump.sv
// Bench for hpdl_buffer_dump: UART line decoder,
// behavioural frame model and timing checks.
module tb_hpdl_buffer_dump;

  localparam int CLK_HZ    = 3000000;
  localparam int BAUD      = 115200;
  localparam int DL        = 16;
  localparam int BIT       = CLK_HZ / BAUD;
  localparam int BYTE_CYC  = 10 * BIT;
  localparam int NB        = DL + 4;
  localparam int FRAME_CYC = NB * BYTE_CYC;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [3:0] addr;
  logic [7:0] rd_data;
  logic       tx;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hpdl_buffer_dump #(
    .CLK_HZ        (CLK_HZ),
    .BAUD          (BAUD),
    .DISPLAY_LENGTH(DL)
  ) dut (
    .CLK_i       (clk),
    .RST_i       (rst),
    .i_dump_start(start),
    .o_rd_address(addr),
    .i_rd_data   (rd_data),
    .UART_TX     (tx),
    .o_busy      (busy),
    .o_done      (done)
  );

  logic [7:0] mem [DL];
  always @(posedge clk) rd_data <= mem[addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rx_q [$];
  int         rx_t [$];
  logic [7:0] exp_q [$];
  int cell_err  = 0;
  int frame_err = 0;

  initial begin : rx_mon
    logic s [BYTE_CYC];
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        t0 = cyc;
        s[0] = tx;
        for (int k = 1; k < BYTE_CYC; k++) begin
          @(negedge clk);
          s[k] = tx;
        end
        for (int k = 0; k < BYTE_CYC; k++)
          if (s[k] !== s[(k / BIT) * BIT + BIT / 2]) cell_err++;
        for (int i = 0; i < 8; i++) b[i] = s[(i + 1) * BIT + BIT / 2];
        if (s[BIT / 2] !== 1'b0 || s[9 * BIT + BIT / 2] !== 1'b1) frame_err++;
        rx_q.push_back(b);
        rx_t.push_back(t0);
      end
    end
  end

  int   done_cnt  = 0;
  int   done_t    = 0;
  int   done_long = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_t = cyc;
      if (done_prev === 1'b1) done_long++;
    end
    done_prev = done;
  end

  function automatic void build_expect();
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(8'h5B);
    for (int i = 0; i < DL; i++) begin
      b = mem[i];
      exp_q.push_back((b >= 8'h20 && b <= 8'h7E) ? b : 8'h2E);
    end
    exp_q.push_back(8'h5D);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic flush();
    rx_q.delete();
    rx_t.delete();
    cell_err  = 0;
    frame_err = 0;
    done_long = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(output int t);
    @(negedge clk);
    start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit, output bit ok);
    int n;
    n = 0;
    while (done_cnt == base && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = (done_cnt != base);
  endtask

  task automatic load_hello();
    string s;
    s = "HELLO WORLD     ";
    for (int i = 0; i < DL; i++) mem[i] = s[i];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    tick(3);
    checks++;
    if (tx !== 1'b1) begin
      failures++; $display("FAIL reset_tx got=%b exp=1", tx);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b exp=0", done);
    end
    checks++;
    if (addr !== 4'd0) begin
      failures++; $display("FAIL reset_addr got=%0d exp=0", addr);
    end
    start = 1'b0;
    rst = 1'b0;
    tick(3);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failures++; $display("FAIL post_reset_idle busy=%b tx=%b exp busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_hello();
    int ts, base;
    bit ok;
    load_hello();
    build_expect();
    flush();
    base = done_cnt;
    pulse_start(ts);
    wait_done(base, FRAME_CYC + 500, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL hello_done_timeout got=none exp=pulse");
    end
    checks++;
    if (rx_q.size() != NB) begin
      failures++; $display("FAIL hello_count got=%0d exp=%0d", rx_q.size(), NB);
    end else begin
      for (int i = 0; i < NB; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL hello_byte[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]);
        end
      end
      checks++;
      if (rx_t[0] != ts + 2) begin
        failures++; $display("FAIL hello_latency got=%0d exp=%0d", rx_t[0], ts + 2);
      end
      checks++;
      if (done_t - rx_t[0] != FRAME_CYC) begin
        failures++; $display("FAIL hello_done_time got=%0d exp=%0d", done_t - rx_t[0], FRAME_CYC);
      end
    end
    tick(50);
    checks++;
    if (done_cnt - base != 1) begin
      failures++; $display("FAIL hello_done_count got=%0d exp=1", done_cnt - base);
    end
    checks++;
    if (cell_err != 0 || frame_err != 0) begin
      failures++; $display("FAIL hello_bit_timing got cell=%0d frame=%0d exp=0", cell_err, frame_err);
    end
    checks++;
    if (busy !== 1'b0 || addr !== 4'd0) begin
      failures++; $display("FAIL hello_idle got busy=%b addr=%0d exp 0/0", busy, addr);
    end
  endtask

  task automatic test_sanitize();
    int ts, base;
    bit ok;
    for (int i = 0; i < DL; i++) mem[i] = 8'h41;
    mem[3] = 8'h07;
    mem[9] = 8'hC1;
    flush();
    base = done_cnt;
    pulse_start(ts);
    wait_done(base, FRAME_CYC + 500, ok);
    checks++;
    if (!ok || rx_q.size() != NB) begin
      failures++; $display("FAIL sanitize_frame got=%0d bytes exp=%0d", rx_q.size(), NB);
    end else begin
      for (int i = 1; i <= DL; i++) begin
        checks++;
        if (rx_q[i] !== ((i == 4 || i == 10) ? 8'h2E : 8'h41)) begin
          failures++; $display("FAIL sanitize_char[%0d] got=%h", i - 1, rx_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int ts, base;
    bit ok;
    for (int i = 0; i < DL; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'h1F;
    mem[1] = 8'h20;
    mem[2] = 8'h7E;
    mem[3] = 8'h7F;
    mem[4] = 8'h80;
    mem[5] = 8'hFF;
    build_expect();
    flush();
    base = done_cnt;
    pulse_start(ts);
    wait_done(base, FRAME_CYC + 500, ok);
    checks++;
    if (!ok || rx_q.size() != NB) begin
      failures++; $display("FAIL random_frame got=%0d bytes exp=%0d", rx_q.size(), NB);
    end else begin
      for (int i = 0; i < NB; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL random_byte[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_start_spam();
    int base, drop;
    bit seen;
    for (int i = 0; i < DL; i++) mem[i] = 8'($urandom_range(32, 126));
    build_expect();
    flush();
    base = done_cnt;
    drop = 0;
    seen = 1'b0;
    for (int k = 0; k < FRAME_CYC + 2000 && done_cnt == base; k++) begin
      @(negedge clk);
      start = (k % 100 == 0);
      #1;
      if (busy === 1'b1) seen = 1'b1;
      else if (seen) drop++;
    end
    start = 1'b0;
    tick(300);
    checks++;
    if (done_cnt - base != 1) begin
      failures++; $display("FAIL spam_done_count got=%0d exp=1", done_cnt - base);
    end
    checks++;
    if (drop != 0 || !seen) begin
      failures++; $display("FAIL spam_busy_drop got=%0d seen=%b exp 0/1", drop, seen);
    end
    checks++;
    if (rx_q.size() != NB) begin
      failures++; $display("FAIL spam_count got=%0d exp=%0d", rx_q.size(), NB);
    end else begin
      for (int i = 0; i < NB; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL spam_byte[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int ts, base, s0, lows, busy_hi;
    bit ok;
    load_hello();
    build_expect();
    flush();
    base = done_cnt;
    pulse_start(ts);
    s0 = ts + 2;
    while (cyc < s0 + 5000) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || addr !== 4'd0) begin
      failures++; $display("FAIL abort_outputs got busy=%b done=%b addr=%0d exp 0", busy, done, addr);
    end
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    busy_hi = 0;
    for (int i = 0; i < 1000; i++) begin
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busy_hi++;
      @(negedge clk);
    end
    checks++;
    if (lows != 0) begin
      failures++; $display("FAIL abort_line got=%0d low cycles exp=0", lows);
    end
    checks++;
    if (busy_hi != 0 || done_cnt != base) begin
      failures++; $display("FAIL abort_state got busy=%0d done=%0d exp 0", busy_hi, done_cnt - base);
    end
    flush();
    pulse_start(ts);
    wait_done(base, FRAME_CYC + 500, ok);
    checks++;
    if (!ok || rx_q.size() != NB) begin
      failures++; $display("FAIL recover_frame got=%0d bytes exp=%0d", rx_q.size(), NB);
    end else begin
      for (int i = 0; i < NB; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL recover_byte[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok1, ok2;
    for (int i = 0; i < DL; i++) mem[i] = 8'($urandom_range(0, 255));
    build_expect();
    flush();
    base = done_cnt;
    @(negedge clk);
    start = 1'b1;
    wait_done(base, FRAME_CYC + 500, ok1);
    wait_done(base + 1, FRAME_CYC + 500, ok2);
    start = 1'b0;
    tick(50);
    checks++;
    if (!ok1 || !ok2 || done_cnt - base != 2) begin
      failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - base);
    end
    checks++;
    if (done_long != 0) begin
      failures++; $display("FAIL b2b_done_width got=%0d long exp=0", done_long);
    end
    checks++;
    if (cell_err != 0 || frame_err != 0) begin
      failures++; $display("FAIL b2b_bit_timing got cell=%0d frame=%0d exp=0", cell_err, frame_err);
    end
    checks++;
    if (rx_q.size() != 2 * NB) begin
      failures++; $display("FAIL b2b_count got=%0d exp=%0d", rx_q.size(), 2 * NB);
    end else begin
      checks++;
      if (rx_t[NB] - rx_t[0] != FRAME_CYC + 3) begin
        failures++; $display("FAIL b2b_period got=%0d exp=%0d", rx_t[NB] - rx_t[0], FRAME_CYC + 3);
      end
      for (int i = 0; i < 2 * NB; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i % NB]) begin
          failures++; $display("FAIL b2b_byte[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i % NB]);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL b2b_idle got busy=%b exp=0", busy);
    end
  endtask

  initial begin
    for (int i = 0; i < DL; i++) mem[i] = 8'h00;
    test_reset();
    test_hello();
    test_sanitize();
    test_random();
    test_start_spam();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
